adc_scan_scheduler: RTL and testbench
=====================================

ADC_SCAN_SCHEDULER -- requirements
Module: adc_scan_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, max cycles to wait for a conversion-done pulse.
REQ-002 The block SHALL have parameter PERIOD_W, default 16, width of the frame-period input and the frame counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 The block SHALL have port run, input, 1, level: scanning enabled.
REQ-006 The block SHALL have port period, input, PERIOD_W, frame period in clk cycles; 0 means back-to-back.
REQ-007 The block SHALL have port clear_error, input, 1, one-cycle pulse that clears the sticky timeout flags.
REQ-008 The block SHALL have port lower_done, input, 1, data-enable pulse from the lower ADC controller.
REQ-009 The block SHALL have port upper_done, input, 1, data-enable pulse from the upper ADC controller.
REQ-010 The block SHALL have port start_lower_adc, output, 1, one-cycle start pulse to the lower ADC controller.
REQ-011 The block SHALL have port start_upper_adc, output, 1, one-cycle start pulse to the upper ADC controller.
REQ-012 The block SHALL have port lower_timeout, output, 1, sticky flag: the lower ADC missed its done pulse.
REQ-013 The block SHALL have port upper_timeout, output, 1, sticky flag: the upper ADC missed its done pulse.
REQ-014 The block SHALL have port frame_count, output, PERIOD_W, number of completed frames.
REQ-015 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, START_LO, WAIT_LO, START_HI, WAIT_HI, GAP; all outputs SHALL be registered or decoded from state only (Moore).
REQ-017 IDLE: run=1 SHALL move the FSM to START_LO on the next cycle; run=0 SHALL keep it in IDLE.
REQ-018 START_LO SHALL last exactly 1 cycle with start_lower_adc=1, then go to WAIT_LO; this cycle is frame start T0.
REQ-019 WAIT_LO: lower_done=1 SHALL move to START_HI; after TIMEOUT_CYCLES cycles without lower_done, lower_timeout SHALL be set and the FSM SHALL move to START_HI.
REQ-020 START_HI and WAIT_HI SHALL mirror REQ-018/REQ-019 with start_upper_adc, upper_done and upper_timeout; leaving WAIT_HI by either exit SHALL increment frame_count, wrapping from all-ones to 0.
REQ-021 The exit from WAIT_HI SHALL go to GAP when run=1 and period > cycles elapsed since T0, to START_LO when run=1 and the period has already elapsed (including period=0), and to IDLE when run=0.
REQ-022 GAP SHALL go to START_LO so that the next start_lower_adc occurs exactly at T0+period; run=0 in GAP SHALL go to IDLE on the next cycle.
REQ-023 The elapsed-cycle counter SHALL be cleared at START_LO and SHALL saturate at all-ones; period SHALL be sampled at START_LO and held for the frame.
REQ-024 The two start outputs SHALL never be high in the same cycle, so the shared serializer never sees concurrent data enables.
REQ-025 Done pulses outside their own WAIT state SHALL be ignored, including a done pulse in the same cycle as its start pulse.
REQ-026 run deasserted during START_LO through WAIT_HI SHALL NOT abort the frame; the frame SHALL complete and the FSM SHALL then return to IDLE.
REQ-027 clear_error SHALL clear both flags; a timeout in the same cycle as clear_error SHALL take priority and leave the flag set.

Reset
REQ-028 reset SHALL take priority over all inputs and SHALL return the FSM to IDLE with start_lower_adc=0, start_upper_adc=0, lower_timeout=0, upper_timeout=0, frame_count=0, busy=0, and both counters cleared.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without incrementing frame_count or emitting further start pulses.

Structure
REQ-030 The shared package SHALL hold the state enum and the default values of TIMEOUT_CYCLES and PERIOD_W.
REQ-031 A sub-module cycle_timer (clear, enable, saturating count, compare-to-limit output) SHALL be instantiated twice: once for the timeout and once for the period.

Verification
REQ-032 Test period=100 with both done pulses 20 cycles after their starts: start_lower_adc SHALL occur at T0, T0+100 and T0+200, start_upper_adc SHALL occur at T0+21, and frame_count SHALL step by 1 per frame.
REQ-033 Test period=0 with done latency 5: frames SHALL run back-to-back, the next start_lower_adc SHALL come 1 cycle after upper_done, and the start outputs SHALL never be high together.
REQ-034 Test lower_done never asserted with TIMEOUT_CYCLES=16: lower_timeout SHALL rise 16 cycles after WAIT_LO entry, start_upper_adc SHALL follow, and the flag SHALL stay set until clear_error.
REQ-035 Test run dropped during WAIT_LO: start_upper_adc SHALL still occur, frame_count SHALL increment by 1, and busy SHALL fall after WAIT_HI.
REQ-036 Test reset pulsed during WAIT_HI: all outputs SHALL be 0 on the next cycle, and frame_count SHALL stay 0.
REQ-037 Test frame_count preloaded via 65535 frames: the next frame SHALL wrap frame_count to 0, and clear_error coincident with a timeout SHALL leave the flag set.

Source files
------------

// File: rtl/adc_scan_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// adc_scan_scheduler_pkg
// Shared definitions for the ADC scan scheduler:
//   - default values of the TIMEOUT_CYCLES and PERIOD_W parameters
//   - the scheduler state enum
//   - a helper that sizes a cycle_timer for a given cycle limit
// ---------------------------------------------------------------------------
package adc_scan_scheduler_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4096;
    localparam int unsigned DEFAULT_PERIOD_W       = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START_LO = 3'd1,
        WAIT_LO  = 3'd2,
        START_HI = 3'd3,
        WAIT_HI  = 3'd4,
        GAP      = 3'd5
    } scan_state_t;

    // Number of bits a counter needs to hold values 0..limit.
    function automatic int unsigned timer_width(input int unsigned limit);
        if (limit < 1) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/adc_scan_scheduler_cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer
// Saturating cycle counter with a compare-to-limit flag.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset, clears the count
//   clear       synchronous clear, count reads 0 on the following cycle
//   enable      advance the count by one this cycle (sticks at all-ones)
//   limit       cycle limit to compare against
//   last_cycle  high when the current cycle is the limit-th cycle since the
//               count was cleared, i.e. count + 1 >= limit
// ---------------------------------------------------------------------------
module cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         last_cycle
);

    logic [W-1:0] count;
    logic [W:0]   count_plus_one;

    // The count holds at all-ones instead of wrapping, so a long wait can
    // never alias back to a small elapsed value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    // The comparison is done one bit wider so the saturated value still
    // compares correctly against an all-ones limit.
    assign count_plus_one = {1'b0, count} + (W + 1)'(1);
    assign last_cycle     = (count_plus_one >= {1'b0, limit});

endmodule

// File: rtl/adc_scan_scheduler.sv
// ---------------------------------------------------------------------------
// adc_scan_scheduler
// Schedules conversions on two ADC controllers (lower then upper) that share
// one serializer. Each frame starts the lower ADC, waits for its done pulse
// (or a timeout), then does the same for the upper ADC, and finally waits
// until the frame period has elapsed before starting the next frame.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-high reset
//   run              level: scanning enabled
//   period           frame period in clk cycles, 0 = back-to-back frames
//   clear_error      one-cycle pulse clearing both sticky timeout flags
//   lower_done       done pulse from the lower ADC controller
//   upper_done       done pulse from the upper ADC controller
//   start_lower_adc  one-cycle start pulse to the lower ADC controller
//   start_upper_adc  one-cycle start pulse to the upper ADC controller
//   lower_timeout    sticky: lower ADC missed its done pulse
//   upper_timeout    sticky: upper ADC missed its done pulse
//   frame_count      number of completed frames (wraps)
//   busy             high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module adc_scan_scheduler
    import adc_scan_scheduler_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned PERIOD_W       = DEFAULT_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clear_error,
    input  logic                lower_done,
    input  logic                upper_done,
    output logic                start_lower_adc,
    output logic                start_upper_adc,
    output logic                lower_timeout,
    output logic                upper_timeout,
    output logic [PERIOD_W-1:0] frame_count,
    output logic                busy
);

    localparam int unsigned TIMEOUT_W = timer_width(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    scan_state_t         state;
    scan_state_t         next_state;
    logic [PERIOD_W-1:0] period_q;
    logic                in_wait;
    logic                wait_expired;
    logic                period_reached;
    logic                lower_timeout_event;
    logic                upper_timeout_event;
    logic                frame_end;

    // Timeout timer: held clear outside the WAIT states, so it reads 0 on
    // the first cycle of each WAIT state. wait_expired marks the last cycle
    // a WAIT state may last before giving up on the done pulse.
    assign in_wait = (state == WAIT_LO) || (state == WAIT_HI);

    cycle_timer #(
        .W (TIMEOUT_W)
    ) u_timeout_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (!in_wait),
        .enable     (1'b1),
        .limit      (TIMEOUT_LIMIT),
        .last_cycle (wait_expired)
    );

    // Frame timer: cleared on the way into START_LO so it reads k on cycle
    // T0+k. period_reached is therefore "by the next cycle, period cycles
    // will have elapsed since T0", which is exactly when the next
    // START_LO must be entered to land on T0+period.
    cycle_timer #(
        .W (PERIOD_W)
    ) u_period_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (next_state == START_LO),
        .enable     (1'b1),
        .limit      (period_q),
        .last_cycle (period_reached)
    );

    // A missed done pulse only counts if the done input is not arriving on
    // that very last cycle; a frame ends on either exit from WAIT_HI.
    assign lower_timeout_event = (state == WAIT_LO) && wait_expired && !lower_done;
    assign upper_timeout_event = (state == WAIT_HI) && wait_expired && !upper_done;
    assign frame_end           = (state == WAIT_HI) && (upper_done || wait_expired);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. run is only consulted in IDLE, at the end of a
    // frame and in GAP, so dropping run mid-frame lets the frame finish.
    // Done inputs are only looked at in their own WAIT state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (run) begin
                    next_state = START_LO;
                end
            end
            START_LO: begin
                next_state = WAIT_LO;
            end
            WAIT_LO: begin
                if (lower_done || wait_expired) begin
                    next_state = START_HI;
                end
            end
            START_HI: begin
                next_state = WAIT_HI;
            end
            WAIT_HI: begin
                if (upper_done || wait_expired) begin
                    if (!run) begin
                        next_state = IDLE;
                    end else if (period_reached) begin
                        next_state = START_LO;
                    end else begin
                        next_state = GAP;
                    end
                end
            end
            GAP: begin
                if (!run) begin
                    next_state = IDLE;
                end else if (period_reached) begin
                    next_state = START_LO;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state alone. Only one START state can be
    // active at a time, so the two start pulses can never coincide.
    always_comb begin
        start_lower_adc = (state == START_LO);
        start_upper_adc = (state == START_HI);
        busy            = (state != IDLE);
    end

    // The period is captured at frame start so a change on the input only
    // affects the following frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= '0;
        end else if (state == START_LO) begin
            period_q <= period;
        end
    end

    // Completed-frame counter, wrapping naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (frame_end) begin
            frame_count <= frame_count + PERIOD_W'(1);
        end
    end

    // Sticky timeout flags. A timeout landing in the same cycle as
    // clear_error wins, so an error is never lost to a concurrent clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            lower_timeout <= 1'b0;
            upper_timeout <= 1'b0;
        end else begin
            if (lower_timeout_event) begin
                lower_timeout <= 1'b1;
            end else if (clear_error) begin
                lower_timeout <= 1'b0;
            end
            if (upper_timeout_event) begin
                upper_timeout <= 1'b1;
            end else if (clear_error) begin
                upper_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_scheduler
// Directed bench for adc_scan_scheduler. dut_a (timeout 64) covers the
// frame timing tests; dut_b (timeout 16) covers timeouts, clear_error and
// frame_count wrap. Both use an 8-bit period/frame counter so the wrap is
// reachable in a short run.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset;

    logic       a_run, a_clear_error, a_lower_done, a_upper_done;
    logic [7:0] a_period;
    logic       a_start_lower_adc, a_start_upper_adc, a_lower_timeout, a_upper_timeout, a_busy;
    logic [7:0] a_frame_count;

    logic       b_run, b_clear_error, b_lower_done, b_upper_done;
    logic [7:0] b_period;
    logic       b_start_lower_adc, b_start_upper_adc, b_lower_timeout, b_upper_timeout, b_busy;
    logic [7:0] b_frame_count;

    int assertions = 0;
    int failures   = 0;
    int cyc        = 0;

    bit a_lo_en = 1'b1, a_hi_en = 1'b1, b_lo_en = 1'b1, b_hi_en = 1'b1;
    int a_lo_lat = 1, a_hi_lat = 1, b_lo_lat = 1, b_hi_lat = 1;
    int a_lo_due = -1, a_hi_due = -1, b_lo_due = -1, b_hi_due = -1;

    int a_lo_q[$];
    int a_hi_q[$];
    int a_lo_fc[$];
    int overlap = 0;

    adc_scan_scheduler #(
        .TIMEOUT_CYCLES (64),
        .PERIOD_W       (8)
    ) dut_a (
        .clk             (clk),
        .reset           (reset),
        .run             (a_run),
        .period          (a_period),
        .clear_error     (a_clear_error),
        .lower_done      (a_lower_done),
        .upper_done      (a_upper_done),
        .start_lower_adc (a_start_lower_adc),
        .start_upper_adc (a_start_upper_adc),
        .lower_timeout   (a_lower_timeout),
        .upper_timeout   (a_upper_timeout),
        .frame_count     (a_frame_count),
        .busy            (a_busy)
    );

    adc_scan_scheduler #(
        .TIMEOUT_CYCLES (16),
        .PERIOD_W       (8)
    ) dut_b (
        .clk             (clk),
        .reset           (reset),
        .run             (b_run),
        .period          (b_period),
        .clear_error     (b_clear_error),
        .lower_done      (b_lower_done),
        .upper_done      (b_upper_done),
        .start_lower_adc (b_start_lower_adc),
        .start_upper_adc (b_start_upper_adc),
        .lower_timeout   (b_lower_timeout),
        .upper_timeout   (b_upper_timeout),
        .frame_count     (b_frame_count),
        .busy            (b_busy)
    );

    // Clock and cycle index: cycle n is the interval after the n-th rising edge.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Start-pulse recorder for dut_a plus a start-overlap counter for both.
    always @(negedge clk) begin
        if (a_start_lower_adc) begin
            a_lo_q.push_back(cyc);
            a_lo_fc.push_back(int'(a_frame_count));
        end
        if (a_start_upper_adc) begin
            a_hi_q.push_back(cyc);
        end
        if ((a_start_lower_adc && a_start_upper_adc) || (b_start_lower_adc && b_start_upper_adc)) begin
            overlap = overlap + 1;
        end
    end

    // ADC controller models: a done pulse lat cycles after the start cycle.
    initial begin
        a_lower_done = 1'b0;
        a_upper_done = 1'b0;
        b_lower_done = 1'b0;
        b_upper_done = 1'b0;
        forever begin
            @(negedge clk);
            if (a_lo_en && a_start_lower_adc) a_lo_due = cyc + a_lo_lat;
            if (a_hi_en && a_start_upper_adc) a_hi_due = cyc + a_hi_lat;
            if (b_lo_en && b_start_lower_adc) b_lo_due = cyc + b_lo_lat;
            if (b_hi_en && b_start_upper_adc) b_hi_due = cyc + b_hi_lat;
            a_lower_done = a_lo_en && (cyc == a_lo_due);
            a_upper_done = a_hi_en && (cyc == a_hi_due);
            b_lower_done = b_lo_en && (cyc == b_lo_due);
            b_upper_done = b_hi_en && (cyc == b_hi_due);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sel_b, input bit run_v, input logic [7:0] period_v, input bit clear_v);
        if (sel_b) begin
            b_run         = run_v;
            b_period      = period_v;
            b_clear_error = clear_v;
        end else begin
            a_run         = run_v;
            a_period      = period_v;
            a_clear_error = clear_v;
        end
    endtask

    task automatic resetDuts();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        a_lo_q.delete();
        a_hi_q.delete();
        a_lo_fc.delete();
    endtask

    task automatic waitIdle(input bit sel_b, input int budget, input string tag, output int fall_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sel_b ? b_busy : a_busy) && n < budget);
        fall_cyc = cyc;
        if (sel_b ? b_busy : a_busy) checkOutput(tag, 1, 0);
    endtask

    task automatic waitLoCount(input int want, input int budget, input string tag);
        int n = 0;
        while (a_lo_q.size() < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (a_lo_q.size() < want) checkOutput(tag, a_lo_q.size(), want);
    endtask

    initial begin
        int fall;
        int t0;
        int rise;
        int n;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset state, with run already high to show reset priority.
        checkOutput("rst_start_lo", a_start_lower_adc, 0);
        checkOutput("rst_start_hi", a_start_upper_adc, 0);
        checkOutput("rst_lower_timeout", a_lower_timeout, 0);
        checkOutput("rst_upper_timeout", a_upper_timeout, 0);
        checkOutput("rst_frame_count", a_frame_count, 0);
        checkOutput("rst_busy", a_busy, 0);

        // period=100, both dones 20 cycles after their starts.
        resetDuts();
        $display("[TB] period=100, done latency 20");
        a_lo_lat = 20;
        a_hi_lat = 20;
        applyStimulus(1'b0, 1'b1, 8'd100, 1'b0);
        waitLoCount(3, 400, "t1_wait_three_frames");
        applyStimulus(1'b0, 1'b0, 8'd100, 1'b0);
        waitIdle(1'b0, 200, "t1_wait_idle", fall);
        checkOutput("t1_lo_count", a_lo_q.size(), 3);
        if (a_lo_q.size() >= 3 && a_hi_q.size() >= 1) begin
            checkOutput("t1_lo1_at_T0+100", a_lo_q[1] - a_lo_q[0], 100);
            checkOutput("t1_lo2_at_T0+200", a_lo_q[2] - a_lo_q[0], 200);
            checkOutput("t1_hi0_at_T0+21", a_hi_q[0] - a_lo_q[0], 21);
            checkOutput("t1_fc_frame0", a_lo_fc[0], 0);
            checkOutput("t1_fc_frame1", a_lo_fc[1], 1);
            checkOutput("t1_fc_frame2", a_lo_fc[2], 2);
        end
        checkOutput("t1_fc_final", a_frame_count, 3);

        // period=0, done latency 5: back-to-back frames.
        resetDuts();
        $display("[TB] period=0, done latency 5");
        a_lo_lat = 5;
        a_hi_lat = 5;
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0);
        waitLoCount(3, 200, "t2_wait_three_frames");
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        waitIdle(1'b0, 100, "t2_wait_idle", fall);
        if (a_lo_q.size() >= 3 && a_hi_q.size() >= 1) begin
            checkOutput("t2_hi0_offset", a_hi_q[0] - a_lo_q[0], 6);
            checkOutput("t2_lo_after_upper_done", a_lo_q[1] - (a_hi_q[0] + 5), 1);
            checkOutput("t2_frame_len", a_lo_q[2] - a_lo_q[1], 12);
        end
        checkOutput("t2_start_overlap", overlap, 0);

        // run dropped during WAIT_LO: frame completes, then idle.
        resetDuts();
        $display("[TB] run dropped in WAIT_LO");
        a_lo_lat = 10;
        a_hi_lat = 10;
        applyStimulus(1'b0, 1'b1, 8'd50, 1'b0);
        waitLoCount(1, 20, "t3_wait_first_start");
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'd50, 1'b0);
        waitIdle(1'b0, 100, "t3_wait_idle", fall);
        repeat (10) @(negedge clk);
        checkOutput("t3_hi_count", a_hi_q.size(), 1);
        checkOutput("t3_lo_count", a_lo_q.size(), 1);
        checkOutput("t3_fc", a_frame_count, 1);
        if (a_hi_q.size() >= 1) begin
            checkOutput("t3_busy_fall_offset", fall - a_hi_q[0], 11);
        end

        // Reset pulsed during WAIT_HI.
        resetDuts();
        $display("[TB] reset during WAIT_HI");
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0);
        n = 0;
        while (a_hi_q.size() < 1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (a_hi_q.size() < 1) checkOutput("t4_wait_hi_start", 0, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        checkOutput("t4_start_lo", a_start_lower_adc, 0);
        checkOutput("t4_start_hi", a_start_upper_adc, 0);
        checkOutput("t4_lower_timeout", a_lower_timeout, 0);
        checkOutput("t4_upper_timeout", a_upper_timeout, 0);
        checkOutput("t4_busy", a_busy, 0);
        checkOutput("t4_fc", a_frame_count, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("t4_no_more_lo", a_lo_q.size(), 1);
        checkOutput("t4_no_more_hi", a_hi_q.size(), 1);
        checkOutput("t4_fc_after", a_frame_count, 0);

        // Lower done never arrives, timeout 16.
        resetDuts();
        $display("[TB] lower ADC timeout");
        b_lo_en  = 1'b0;
        b_hi_en  = 1'b1;
        b_hi_lat = 3;
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_start_lower_adc && n < 20);
        t0 = cyc;
        if (!b_start_lower_adc) checkOutput("t5_wait_lo_start", 0, 1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_lower_timeout && n < 40);
        rise = cyc;
        checkOutput("t5_flag_rise_offset", rise - t0, 17);
        checkOutput("t5_start_hi_follows", b_start_upper_adc, 1);
        waitIdle(1'b1, 40, "t5_wait_idle", fall);
        repeat (10) @(negedge clk);
        checkOutput("t5_flag_sticky", b_lower_timeout, 1);
        checkOutput("t5_upper_flag_clear", b_upper_timeout, 0);
        checkOutput("t5_fc", b_frame_count, 1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("t5_flag_cleared", b_lower_timeout, 0);

        // 255 fast frames, then a wrapping frame whose upper timeout
        // coincides with clear_error.
        resetDuts();
        $display("[TB] frame_count wrap and clear_error vs timeout");
        b_lo_en  = 1'b1;
        b_lo_lat = 1;
        b_hi_en  = 1'b1;
        b_hi_lat = 1;
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b_frame_count != 8'd255 && n < 1500);
        if (b_frame_count != 8'd255) checkOutput("t6_wait_fc_255", b_frame_count, 255);
        checkOutput("t6_next_frame_starts", b_start_lower_adc, 1);
        b_hi_en = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_start_upper_adc && n < 20);
        if (!b_start_upper_adc) checkOutput("t6_wait_hi_start", 0, 1);
        repeat (16) @(negedge clk);
        checkOutput("t6_no_early_timeout", b_upper_timeout, 0);
        checkOutput("t6_fc_before_wrap", b_frame_count, 255);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("t6_timeout_beats_clear", b_upper_timeout, 1);
        checkOutput("t6_fc_wrapped", b_frame_count, 0);
        checkOutput("t6_idle_after_frame", b_busy, 0);
        @(negedge clk);
        checkOutput("t6_flag_still_set", b_upper_timeout, 1);

        checkOutput("start_overlap_total", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
